// File: rtl/rvvi_frame_decoder.sv
// rtl/rvvi_frame_decoder.sv - RVVI trace frame receiver: checks magic/length/sequence and unpacks fields
module rvvi_frame_decoder #(
    parameter int          XLEN              = 64,
    parameter int          MAX_CSRS          = 5,
    parameter int          FRAME_COUNT_WIDTH = 16,
    parameter int          ERR_COUNT_WIDTH   = 16,
    parameter logic [15:0] MAGIC             = 16'h5256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   InWord,
    input  logic                          InValid,
    input  logic                          InLast,
    output logic                          InReady,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic [XLEN-1:0]               PC,
    output logic [XLEN-1:0]               GPRValue,
    output logic [XLEN-1:0]               FPRValue,
    output logic [31:0]                   Instr,
    output logic [63:0]                   Mcycle,
    output logic [63:0]                   Minstret,
    output logic                          Trap,
    output logic [1:0]                    PrivMode,
    output logic                          GPRWen,
    output logic                          FPRWen,
    output logic [4:0]                    GPRAddr,
    output logic [4:0]                    FPRAddr,
    output logic [11:0]                   CSRCount,
    output logic [MAX_CSRS-1:0]           CSRValid,
    output logic [MAX_CSRS*12-1:0]        CSRAddr,
    output logic [MAX_CSRS*XLEN-1:0]      CSRValue,
    output logic [FRAME_COUNT_WIDTH-1:0]  FrameCount,
    output logic [ERR_COUNT_WIDTH-1:0]    DropCount,
    output logic [ERR_COUNT_WIDTH-1:0]    SeqErrCount
);

    localparam int FIXED_W   = (3 * XLEN + 200 + 31) / 32;
    localparam int FW        = FIXED_W * 32;
    localparam int CW        = (XLEN + 16 + 31) / 32;
    localparam int CSRB      = MAX_CSRS * CW * 32;
    localparam int OFF_INSTR = XLEN;
    localparam int OFF_MCYC  = XLEN + 32;
    localparam int OFF_MINST = XLEN + 96;
    localparam int OFF_TRAP  = XLEN + 160;
    localparam int OFF_CSRC  = XLEN + 168;
    localparam int OFF_GADDR = XLEN + 184;
    localparam int OFF_GVAL  = XLEN + 192;
    localparam int OFF_FADDR = 2 * XLEN + 192;
    localparam int OFF_FVAL  = 2 * XLEN + 200;

    typedef enum logic [2:0] {S_HUNT, S_FIXED, S_CSR, S_DRAIN, S_HOLD} state_t;

    state_t                         state_q;
    logic [7:0]                     cnt_q;
    logic [FW-1:0]                  fix_q, fix_d;
    logic [CSRB-1:0]                csr_q, csr_d;
    logic [11:0]                    ncsr_q, ncnt_w;
    logic [7:0]                     ncsr_words_q;
    logic [15:0]                    hdr_q;
    logic [FRAME_COUNT_WIDTH-1:0]   hdr_fc_w, prev_q;
    logic                           first_q;
    logic                           accept_w, magic_w, last_fix_w, last_csr_w, hold_w, drop_w;
    logic [MAX_CSRS-1:0]            csr_valid_d;
    logic [MAX_CSRS*12-1:0]         csr_addr_d;
    logic [MAX_CSRS*XLEN-1:0]       csr_value_d;
    logic                           unused_bits;

    assign InReady  = (state_q != S_HOLD);
    assign accept_w = InValid && InReady;
    assign magic_w  = (InWord[31:16] == MAGIC);
    assign hdr_fc_w = FRAME_COUNT_WIDTH'(hdr_q);

    // Fixed words shift in from the top so word 0 ends up at bit 0 after FIXED_W words.
    always_comb begin
        fix_d = fix_q;
        csr_d = csr_q;
        if (state_q == S_FIXED && accept_w)
            fix_d = {InWord, fix_q[FW-1:32]};
        if (state_q == S_CSR && accept_w)
            csr_d[{cnt_q, 5'b0} +: 32] = InWord;
    end

    assign ncnt_w     = (state_q == S_FIXED) ? fix_d[OFF_CSRC +: 12] : ncsr_q;
    assign last_fix_w = (state_q == S_FIXED) && accept_w && (cnt_q == 8'(FIXED_W - 1));
    assign last_csr_w = (state_q == S_CSR) && accept_w && (cnt_q == ncsr_words_q - 8'd1);
    assign hold_w     = InLast && ((last_fix_w && ncnt_w == 12'd0) || last_csr_w);
    assign drop_w     = (state_q == S_HUNT && accept_w && magic_w && InLast)
                      || (state_q == S_FIXED && accept_w && !last_fix_w && InLast)
                      || (last_fix_w && ((ncnt_w > 12'(MAX_CSRS)) || ((ncnt_w == 12'd0) != InLast)))
                      || (state_q == S_CSR && accept_w && !last_csr_w && InLast)
                      || (last_csr_w && !InLast);

    always_comb begin
        csr_valid_d = '0;
        csr_addr_d  = '0;
        csr_value_d = '0;
        for (int i = 0; i < MAX_CSRS; i++) begin
            if (12'(i) < ncnt_w) begin
                csr_valid_d[i]              = 1'b1;
                csr_addr_d[12*i +: 12]      = csr_d[i*CW*32 +: 12];
                csr_value_d[XLEN*i +: XLEN] = csr_d[i*CW*32 + 16 +: XLEN];
            end
        end
    end

    assign unused_bits = ^{fix_d, csr_d, hdr_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_HUNT;
            cnt_q        <= '0;
            fix_q        <= '0;
            csr_q        <= '0;
            ncsr_q       <= '0;
            ncsr_words_q <= '0;
            hdr_q        <= '0;
            prev_q       <= '0;
            first_q      <= 1'b1;
            OutValid     <= 1'b0;
            PC           <= '0;
            GPRValue     <= '0;
            FPRValue     <= '0;
            Instr        <= '0;
            Mcycle       <= '0;
            Minstret     <= '0;
            Trap         <= 1'b0;
            PrivMode     <= '0;
            GPRWen       <= 1'b0;
            FPRWen       <= 1'b0;
            GPRAddr      <= '0;
            FPRAddr      <= '0;
            CSRCount     <= '0;
            CSRValid     <= '0;
            CSRAddr      <= '0;
            CSRValue     <= '0;
            FrameCount   <= '0;
            DropCount    <= '0;
            SeqErrCount  <= '0;
        end else begin
            fix_q <= fix_d;
            csr_q <= csr_d;
            case (state_q)
                S_HUNT: begin
                    if (accept_w && magic_w && !InLast) begin
                        state_q <= S_FIXED;
                        cnt_q   <= '0;
                        hdr_q   <= InWord[15:0];
                    end
                end
                S_FIXED: begin
                    if (accept_w) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (last_fix_w) begin
                            cnt_q        <= '0;
                            ncsr_q       <= ncnt_w;
                            ncsr_words_q <= 8'(ncnt_w) * 8'(CW);
                            if (hold_w)
                                state_q <= S_HOLD;
                            else if (ncnt_w > 12'(MAX_CSRS))
                                state_q <= InLast ? S_HUNT : S_DRAIN;
                            else if (ncnt_w == 12'd0)
                                state_q <= S_DRAIN;
                            else
                                state_q <= InLast ? S_HUNT : S_CSR;
                        end else if (InLast) begin
                            state_q <= S_HUNT;
                        end
                    end
                end
                S_CSR: begin
                    if (accept_w) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (last_csr_w)
                            state_q <= InLast ? S_HOLD : S_DRAIN;
                        else if (InLast)
                            state_q <= S_HUNT;
                    end
                end
                S_DRAIN: begin
                    if (accept_w && InLast)
                        state_q <= S_HUNT;
                end
                S_HOLD: begin
                    if (OutReady) begin
                        state_q  <= S_HUNT;
                        OutValid <= 1'b0;
                    end
                end
                default: state_q <= S_HUNT;
            endcase

            if (drop_w && DropCount != '1)
                DropCount <= DropCount + ERR_COUNT_WIDTH'(1);

            if (hold_w) begin
                OutValid   <= 1'b1;
                PC         <= fix_d[0 +: XLEN];
                Instr      <= fix_d[OFF_INSTR +: 32];
                Mcycle     <= fix_d[OFF_MCYC +: 64];
                Minstret   <= fix_d[OFF_MINST +: 64];
                Trap       <= fix_d[OFF_TRAP];
                PrivMode   <= fix_d[OFF_TRAP + 1 +: 2];
                GPRWen     <= fix_d[OFF_TRAP + 3];
                FPRWen     <= fix_d[OFF_TRAP + 4];
                CSRCount   <= ncnt_w;
                GPRAddr    <= fix_d[OFF_GADDR +: 5];
                GPRValue   <= fix_d[OFF_GVAL +: XLEN];
                FPRAddr    <= fix_d[OFF_FADDR +: 5];
                FPRValue   <= fix_d[OFF_FVAL +: XLEN];
                CSRValid   <= csr_valid_d;
                CSRAddr    <= csr_addr_d;
                CSRValue   <= csr_value_d;
                FrameCount <= hdr_fc_w;
                prev_q     <= hdr_fc_w;
                first_q    <= 1'b0;
                if (!first_q && hdr_fc_w != prev_q + FRAME_COUNT_WIDTH'(1) && SeqErrCount != '1)
                    SeqErrCount <= SeqErrCount + ERR_COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_rvvi_frame_decoder.sv
// tb/tb_rvvi_frame_decoder.sv - directed and random frame tests against a field-level model
module tb_rvvi_frame_decoder;
    localparam int XLEN = 64;
    localparam int MC   = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       InWord = '0;
    logic              InValid = 1'b0, InLast = 1'b0, OutReady = 1'b0;
    logic              InReady, OutValid;
    logic [XLEN-1:0]   PC, GPRValue, FPRValue;
    logic [31:0]       Instr;
    logic [63:0]       Mcycle, Minstret;
    logic              Trap, GPRWen, FPRWen;
    logic [1:0]        PrivMode;
    logic [4:0]        GPRAddr, FPRAddr;
    logic [11:0]       CSRCount;
    logic [MC-1:0]     CSRValid;
    logic [MC*12-1:0]  CSRAddr;
    logic [MC*XLEN-1:0] CSRValue;
    logic [15:0]       FrameCount, DropCount, SeqErrCount;

    rvvi_frame_decoder #(.XLEN(XLEN), .MAX_CSRS(MC)) dut (
        .clk(clk), .reset(reset), .InWord(InWord), .InValid(InValid), .InLast(InLast),
        .InReady(InReady), .OutValid(OutValid), .OutReady(OutReady), .PC(PC),
        .GPRValue(GPRValue), .FPRValue(FPRValue), .Instr(Instr), .Mcycle(Mcycle),
        .Minstret(Minstret), .Trap(Trap), .PrivMode(PrivMode), .GPRWen(GPRWen),
        .FPRWen(FPRWen), .GPRAddr(GPRAddr), .FPRAddr(FPRAddr), .CSRCount(CSRCount),
        .CSRValid(CSRValid), .CSRAddr(CSRAddr), .CSRValue(CSRValue),
        .FrameCount(FrameCount), .DropCount(DropCount), .SeqErrCount(SeqErrCount));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int exp_drop = 0, exp_seq = 0;
    bit first_good = 1'b1;
    logic [15:0] prev_fc = '0;
    logic [63:0] lg_pc = '0;

    logic [63:0] f_pc, f_mcyc, f_minst, f_gval, f_fval;
    logic [31:0] f_instr;
    logic        f_trap, f_gwen, f_fwen;
    logic [1:0]  f_priv;
    logic [4:0]  f_gaddr, f_faddr;
    logic [15:0] f_fc;
    int          f_ncsr;
    logic [11:0] f_caddr[8];
    logic [63:0] f_cval[8];
    logic [31:0] wq[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_frame(input logic [15:0] fc, input int ncsr);
        f_pc = {$urandom, $urandom};   f_instr = $urandom;
        f_mcyc = {$urandom, $urandom}; f_minst = {$urandom, $urandom};
        f_trap = 1'($urandom);         f_priv = 2'($urandom);
        f_gwen = 1'($urandom);         f_fwen = 1'($urandom);
        f_gaddr = 5'($urandom);        f_faddr = 5'($urandom);
        f_gval = {$urandom, $urandom}; f_fval = {$urandom, $urandom};
        f_fc = fc; f_ncsr = ncsr;
        for (int i = 0; i < 8; i++) begin
            f_caddr[i] = 12'($urandom);
            f_cval[i]  = {$urandom, $urandom};
        end
    endtask

    // Serialise the current frame fields into 32-bit link words.
    task automatic build();
        logic [415:0] fx;
        logic [95:0]  e;
        wq.delete();
        wq.push_back({16'h5256, f_fc});
        fx = '0;
        fx[63:0] = f_pc;      fx[95:64] = f_instr;
        fx[159:96] = f_mcyc;  fx[223:160] = f_minst;
        fx[224] = f_trap;     fx[226:225] = f_priv;
        fx[227] = f_gwen;     fx[228] = f_fwen;
        fx[243:232] = 12'(f_ncsr);
        fx[252:248] = f_gaddr; fx[319:256] = f_gval;
        fx[324:320] = f_faddr; fx[391:328] = f_fval;
        for (int k = 0; k < 13; k++) wq.push_back(fx[32*k +: 32]);
        for (int i = 0; i < f_ncsr; i++) begin
            e = '0;
            e[11:0]  = f_caddr[i];
            e[79:16] = f_cval[i];
            for (int k = 0; k < 3; k++) wq.push_back(e[32*k +: 32]);
        end
    endtask

    task automatic send(input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            int t;
            @(negedge clk);
            InValid = 1'b1; InWord = wq[i]; InLast = (i == last_idx);
            t = 0;
            while (!InReady && t < 50) begin @(negedge clk); t++; end
            if (!InReady) begin
                total++; bad++;
                $error("FAIL in_ready_timeout observed=0 expected=1");
            end
        end
        @(negedge clk);
        InValid = 1'b0; InLast = 1'b0; InWord = '0;
    endtask

    task automatic send_garbage(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            InValid = 1'b1; InWord = {16'h1234, 16'($urandom)}; InLast = 1'($urandom);
        end
        @(negedge clk);
        InValid = 1'b0; InLast = 1'b0; InWord = '0;
    endtask

    function automatic logic [MC*XLEN-1:0] exp_cval();
        exp_cval = '0;
        for (int i = 0; i < f_ncsr; i++) exp_cval[XLEN*i +: XLEN] = f_cval[i];
    endfunction

    function automatic logic [MC*12-1:0] exp_caddr();
        exp_caddr = '0;
        for (int i = 0; i < f_ncsr; i++) exp_caddr[12*i +: 12] = f_caddr[i];
    endfunction

    task automatic check_good();
        if (!first_good && f_fc != prev_fc + 16'd1) exp_seq++;
        prev_fc = f_fc; first_good = 1'b0; lg_pc = f_pc;
        chk("out_valid", OutValid, 1);
        chk("pc", PC, f_pc);
        chk("instr", Instr, f_instr);
        chk("mcycle", Mcycle, f_mcyc);
        chk("minstret", Minstret, f_minst);
        chk("flags", {Trap, PrivMode, GPRWen, FPRWen}, {f_trap, f_priv, f_gwen, f_fwen});
        chk("gpr", {GPRAddr, GPRValue}, {f_gaddr, f_gval});
        chk("fpr", {FPRAddr, FPRValue}, {f_faddr, f_fval});
        chk("csr_count", CSRCount, f_ncsr);
        chk("csr_valid", CSRValid, (1 << f_ncsr) - 1);
        chk("csr_addr", CSRAddr, exp_caddr());
        chk("csr_value", CSRValue, exp_cval());
        chk("frame_count", FrameCount, f_fc);
        chk("drop_count", DropCount, exp_drop);
        chk("seq_err_count", SeqErrCount, exp_seq);
    endtask

    task automatic take();
        OutReady = 1'b1;
        @(negedge clk);
        OutReady = 1'b0;
        chk("out_valid_clear", OutValid, 0);
        chk("in_ready_back", InReady, 1);
    endtask

    task automatic run_good(input int hold);
        build();
        send(wq.size(), wq.size() - 1);
        check_good();
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_in_ready", InReady, 0);
            chk("hold_out_valid", OutValid, 1);
            chk("hold_pc", PC, f_pc);
            chk("hold_csr_value", CSRValue, exp_cval());
        end
        take();
    endtask

    task automatic check_drop();
        exp_drop++;
        chk("drop_count", DropCount, exp_drop);
        chk("drop_no_out_valid", OutValid, 0);
        chk("drop_pc_kept", PC, lg_pc);
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid", OutValid, 0);
        chk("rst_in_ready", InReady, 1);
        chk("rst_fields", {PC, Instr, Mcycle, Minstret, GPRValue, FPRValue}, 0);
        chk("rst_csr", {CSRCount, CSRValid, CSRAddr, CSRValue}, 0);
        chk("rst_counters", {FrameCount, DropCount, SeqErrCount}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check_reset_state();

        // Minimal frame with no CSR entries
        rand_frame(16'd7, 0);
        f_pc = 64'h8000_0000; f_instr = 32'h0050_0093;
        run_good(0);

        // Two CSR entries with a back-pressured consumer
        rand_frame(16'd8, 2);
        f_caddr[0] = 12'h300; f_caddr[1] = 12'h341;
        run_good(5);

        // Too many CSRs, then a good frame
        rand_frame(16'd9, 6);
        build(); send(wq.size(), wq.size() - 1);
        check_drop();
        rand_frame(16'd10, 1);
        run_good(1);

        // Garbage words are ignored silently
        send_garbage(4);
        chk("garbage_no_drop", DropCount, exp_drop);
        rand_frame(16'd11, 3);
        run_good(0);

        // InLast on fixed word 5
        rand_frame(16'd12, 0);
        build(); send(6, 5);
        check_drop();

        // Reset in the middle of the CSR section
        rand_frame(16'd13, 2);
        build(); send(16, -1);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        exp_drop = 0; exp_seq = 0; first_good = 1'b1; lg_pc = '0;
        check_reset_state();

        // Sequence wrap and gap
        rand_frame(16'hFFFF, 1); run_good(0);
        rand_frame(16'h0000, 0); run_good(0);
        rand_frame(16'h0002, 2); run_good(0);
        chk("seq_err_one", SeqErrCount, 1);

        for (int it = 0; it < 30; it++) begin
            int kind, idx, k;
            logic [15:0] fc;
            kind = $urandom_range(0, 9);
            fc = ($urandom_range(0, 3) == 0) ? 16'($urandom) : prev_fc + 16'd1;
            if ($urandom_range(0, 4) == 0) send_garbage($urandom_range(1, 3));
            if (kind <= 5) begin
                rand_frame(fc, $urandom_range(0, MC));
                run_good($urandom_range(0, 3));
            end else if (kind == 6) begin
                rand_frame(fc, $urandom_range(MC + 1, 7));
                build(); send(wq.size(), wq.size() - 1);
                check_drop();
            end else if (kind == 7) begin
                rand_frame(fc, $urandom_range(1, MC));
                build();
                idx = $urandom_range(0, 13);
                send(idx + 1, idx);
                check_drop();
            end else if (kind == 8) begin
                k = $urandom_range(1, MC);
                rand_frame(fc, k);
                build();
                idx = $urandom_range(14, 14 + 3 * k - 2);
                send(idx + 1, idx);
                check_drop();
            end else begin
                rand_frame(fc, $urandom_range(0, 2));
                build();
                wq.push_back(32'hDEAD_BEEF);
                send(wq.size(), wq.size() - 1);
                check_drop();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
